// File: rtl/binary_search_ctrl_pkg.sv
// Shared definitions for the binary search controller: FSM state encoding,
// default operand width and the comparator flag sanity check.
package binary_search_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The external comparator is trusted only when exactly one flag is high.
  function automatic logic flags_onehot(input logic less, input logic greater,
                                        input logic equal);
    logic [2:0] f;
    f = {less, greater, equal};
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

endpackage

// File: rtl/binary_search_ctrl_next_bounds.sv
// Next-bounds datapath for one binary search step: narrows [lo, hi] from the
// comparator direction, flags an empty interval and forms the next midpoint.
// lo is unsigned (0 .. 2^WIDTH) and hi is signed (-1 .. 2^WIDTH-1); both fit in
// WIDTH+1 bits, so stepping past either end of the range never wraps.
module bsc_next_bounds
  import binary_search_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   lo_i,
  input  logic [WIDTH:0]   hi_i,
  input  logic [WIDTH-1:0] trial_i,
  input  logic             less_i,
  input  logic             greater_i,
  output logic [WIDTH:0]   lo_o,
  output logic [WIDTH:0]   hi_o,
  output logic [WIDTH-1:0] trial_o,
  output logic             empty_o
);

  localparam logic [WIDTH:0] ONE_W = (WIDTH+1)'(1);

  logic        [WIDTH:0]   lo_n;
  logic signed [WIDTH:0]   hi_n;
  logic signed [WIDTH+1:0] lo_ext;
  logic signed [WIDTH+1:0] hi_ext;
  logic signed [WIDTH+1:0] sum_s;

  // Bound update, emptiness test and midpoint of the narrowed interval.
  always_comb begin
    lo_n = lo_i;
    hi_n = signed'(hi_i);
    if (less_i) begin
      lo_n = {1'b0, trial_i} + ONE_W;
    end
    if (greater_i) begin
      hi_n = signed'({1'b0, trial_i}) - signed'(ONE_W);
    end
    // Widen by one bit with each bound's own signedness before comparing.
    lo_ext  = signed'({1'b0, lo_n});
    hi_ext  = signed'({hi_n[WIDTH], hi_n});
    empty_o = lo_ext > hi_ext;
    // Only meaningful when the interval is non-empty; then the sum is in range.
    sum_s   = lo_ext + hi_ext;
    trial_o = WIDTH'(sum_s >>> 1);
    lo_o    = lo_n;
    hi_o    = hi_n;
  end

endmodule

// File: rtl/binary_search_ctrl.sv
// Binary search controller: drives a registered probe value into an external
// magnitude comparator and walks [lo, hi] until it hits equal, the interval
// empties, or the comparator returns an invalid flag combination.
module binary_search_ctrl
  import binary_search_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [WIDTH-1:0]            trial,
  input  logic                        cmp_less,
  input  logic                        cmp_greater,
  input  logic                        cmp_equal,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic                        err,
  output logic [WIDTH-1:0]            result,
  output logic [$clog2(WIDTH+2)-1:0]  probes
);

  localparam int CNT_W = $clog2(WIDTH+2);
  localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] TRIAL_INIT = {1'b0, {(WIDTH-1){1'b1}}};

  state_e             state_q, state_d;
  logic [WIDTH:0]     lo_q, lo_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   trial_q, trial_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]     nb_lo;
  logic [WIDTH:0]     nb_hi;
  logic [WIDTH-1:0]   nb_trial;
  logic               nb_empty;
  logic               flags_ok;

  bsc_next_bounds #(
    .WIDTH     (WIDTH)
  ) u_next_bounds (
    .lo_i      (lo_q),
    .hi_i      (hi_q),
    .trial_i   (trial_q),
    .less_i    (cmp_less),
    .greater_i (cmp_greater),
    .lo_o      (nb_lo),
    .hi_o      (nb_hi),
    .trial_o   (nb_trial),
    .empty_o   (nb_empty)
  );

  assign flags_ok = flags_onehot(cmp_less, cmp_greater, cmp_equal);

  // FSM next-state and search bookkeeping.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    trial_d  = trial_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_PROBE;
          lo_d     = '0;
          hi_d     = HI_INIT;
          trial_d  = TRIAL_INIT;
          cnt_d    = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
        end
      end
      ST_PROBE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!flags_ok) begin
          // Result stays at its cleared value; found already 0 from start.
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = ST_DONE;
        end else if (cmp_equal) begin
          result_d = trial_q;
          found_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          lo_d = nb_lo;
          hi_d = nb_hi;
          if (nb_empty) begin
            state_d = ST_DONE;
          end else begin
            trial_d = nb_trial;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any search in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      trial_q  <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      trial_q  <= trial_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign probes = cnt_q;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Testbench for binary_search_ctrl with an 8-bit magnitude comparator model
// (b = target) and flag-override modes for fault injection.
module tb_binary_search_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] trial;
  logic         cmp_less, cmp_greater, cmp_equal;
  logic         busy, done, found, err;
  logic [W-1:0] result;
  logic [3:0]   probes;

  // comparator stimulus controls
  logic [W-1:0] target;
  int           mode;      // 0 normal, 1 always less, 2 always greater, 3 bad flags at probe bad_at
  int           bad_at;
  logic [2:0]   bad_val;   // {less, greater, equal}
  int           probe_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  typedef struct {
    int         target;
    int         mode;
    int         bad_at;
    logic [2:0] bad_val;
    int         restart_at;
    logic       exp_found;
    logic       exp_err;
    int         exp_result;
    int         exp_probes;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  binary_search_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .trial       (trial),
    .cmp_less    (cmp_less),
    .cmp_greater (cmp_greater),
    .cmp_equal   (cmp_equal),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .err         (err),
    .result      (result),
    .probes      (probes)
  );

  // 8-bit magnitude comparator, a = trial, b = target, with overrides
  always_comb begin
    cmp_less    = (trial < target);
    cmp_greater = (trial > target);
    cmp_equal   = (trial == target);
    case (mode)
      1: {cmp_less, cmp_greater, cmp_equal} = 3'b100;
      2: {cmp_less, cmp_greater, cmp_equal} = 3'b010;
      3: if (probe_idx == bad_at) {cmp_less, cmp_greater, cmp_equal} = bad_val;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference binary search: pushes the expected probe sequence.
  task automatic push_model(input int tgt, input int md, input int bad_k);
    int lo, hi, t, k;
    lo = 0;
    hi = (1 << W) - 1;
    k  = 0;
    while (k < 20) begin
      t = (lo + hi) / 2;
      k++;
      exp_q.push_back(t);
      if (md == 3 && k == bad_k) break;
      if (md == 1)       lo = t + 1;
      else if (md == 2)  hi = t - 1;
      else if (t == tgt) break;
      else if (t < tgt)  lo = t + 1;
      else               hi = t - 1;
      if (lo > hi) break;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " trial"},  trial,  0);
    check({tag, " busy"},   busy,   0);
    check({tag, " done"},   done,   0);
    check({tag, " found"},  found,  0);
    check({tag, " err"},    err,    0);
    check({tag, " result"}, result, 0);
    check({tag, " probes"}, probes, 0);
  endtask

  task automatic run_case(input vec_t v, input int idx);
    bit    got_done;
    string tag;
    tag = $sformatf("case%0d", idx);
    exp_q.delete();
    push_model(v.target, v.mode, v.bad_at);
    @(negedge clk);
    target    = W'(v.target);
    mode      = v.mode;
    bad_at    = v.bad_at;
    bad_val   = v.bad_val;
    probe_idx = 0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    got_done = 0;
    for (int cyc = 1; cyc <= W + 4; cyc++) begin
      probe_idx = cyc;
      if (cyc == v.restart_at)          start = 1'b1;
      else if (cyc == v.restart_at + 1) start = 1'b0;
      if (done) begin
        got_done = 1;
        check({tag, " done cycle"}, cyc, v.exp_probes + 1);
        check({tag, " busy@done"}, busy, 1);
        check({tag, " found"},  found,  v.exp_found);
        check({tag, " err"},    err,    v.exp_err);
        check({tag, " result"}, result, v.exp_result);
        check({tag, " probes"}, probes, v.exp_probes);
        check({tag, " unused probes"}, exp_q.size(), 0);
        break;
      end
      check({tag, " busy"}, busy, 1);
      if (exp_q.size() > 0) begin
        check($sformatf("%s trial%0d", tag, cyc), trial, exp_q.pop_front());
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL %s extra probe: got trial %0d, expected no probe", tag, trial);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (!got_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no done, expected done by cycle %0d", tag, v.exp_probes + 1);
    end
    // Two idle cycles: done is a single pulse, results hold, no queued start.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check({tag, " idle done"},   done,   0);
      check({tag, " idle busy"},   busy,   0);
      check({tag, " hold found"},  found,  v.exp_found);
      check({tag, " hold err"},    err,    v.exp_err);
      check({tag, " hold result"}, result, v.exp_result);
      check({tag, " hold probes"}, probes, v.exp_probes);
    end
    mode = 0;
  endtask

  initial begin
    //            tgt mode bad bval    rst fnd err res prb
    tbl[0]  = '{127, 0, 0, 3'b000, 0, 1'b1, 1'b0, 127, 1};
    tbl[1]  = '{255, 0, 0, 3'b000, 0, 1'b1, 1'b0, 255, 9};
    tbl[2]  = '{  0, 0, 0, 3'b000, 0, 1'b1, 1'b0,   0, 8};
    tbl[3]  = '{ 64, 0, 0, 3'b000, 0, 1'b1, 1'b0,  64, 8};
    tbl[4]  = '{  1, 0, 0, 3'b000, 0, 1'b1, 1'b0,   1, 7};
    tbl[5]  = '{200, 0, 0, 3'b000, 3, 1'b1, 1'b0, 200, 8};
    tbl[6]  = '{255, 3, 3, 3'b000, 0, 1'b0, 1'b1,   0, 3};
    tbl[7]  = '{ 50, 3, 1, 3'b101, 0, 1'b0, 1'b1,   0, 1};
    tbl[8]  = '{ 10, 1, 0, 3'b000, 0, 1'b0, 1'b0,   0, 9};
    tbl[9]  = '{ 10, 2, 0, 3'b000, 0, 1'b0, 1'b0,   0, 8};
    tbl[10] = '{254, 3, 2, 3'b111, 0, 1'b0, 1'b1,   0, 2};

    rst_n     = 1'b0;
    start     = 1'b0;
    target    = '0;
    mode      = 0;
    bad_at    = 0;
    bad_val   = 3'b000;
    probe_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_case(tbl[i], i);
    end

    // Reset mid-search: abort with everything cleared and no done pulse.
    @(negedge clk);
    target = 8'd255;
    mode   = 0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    check("midreset done held", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case(tbl[0], 100);

    // Start held high: search restarts right after the DONE cycle.
    @(negedge clk);
    target = 8'd127;
    mode   = 0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    check("held c1 busy",  busy,  1);
    check("held c1 trial", trial, 127);
    @(posedge clk);
    #1;
    check("held c2 done",  done,  1);
    @(posedge clk);
    #1;
    check("held c3 busy",  busy,  0);
    check("held c3 done",  done,  0);
    check("held c3 probes", probes, 1);
    @(posedge clk);
    #1;
    check("held c4 busy",  busy,  1);
    check("held c4 trial", trial, 127);
    check("held c4 probes", probes, 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("held c5 done",  done,  1);
    check("held c5 result", result, 127);
    @(posedge clk);
    #1;
    check("held c6 busy",  busy,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
